// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared width default and PWM period helper for pwm_generator
package pwm_pkg;

  localparam int DW_DEFAULT = 4;

  function automatic int period_of(input int dw);
    return (1 << dw) - 1;
  endfunction

  localparam int PERIOD = period_of(DW_DEFAULT);

endpackage

// File: rtl/pwm_generator_if.sv
// rtl/pwm_generator_if.sv - duty code in, PWM and period strobe out
interface pwm_generator_if
  import pwm_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic [DW-1:0] ADC;
  logic          PWM;
  logic          PERIOD_STB;

  modport master (output ADC, input PWM, input PERIOD_STB);
  modport slave  (input ADC, output PWM, output PERIOD_STB);

endinterface

// File: rtl/pwm_prescaler.sv
// rtl/pwm_prescaler.sv - tick enable every PRESC_DIV clocks, used under PWM_PRESCALE_EN
module pwm_prescaler #(
  parameter int PRESC_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESC_DIV - 1);

  logic [15:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - single-channel PWM, duty latched per period; optional PWM_PRESCALE_EN
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int DW        = DW_DEFAULT,
  parameter int PRESC_DIV = 1
) (
  input  logic             cLK,
  input  logic             rst_n,
  pwm_generator_if.slave   bus
);

  localparam logic [DW-1:0] LAST = DW'(period_of(DW) - 1);

  logic          tick;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_next;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] duty_next;
  logic          pwm_q;
  logic          stb_q;

  if (PRESC_DIV < 1 || PRESC_DIV > 65535) begin : g_bad_div
    $error("pwm_generator: PRESC_DIV out of range 1..65535");
  end

`ifdef PWM_PRESCALE_EN
  pwm_prescaler #(
    .PRESC_DIV (PRESC_DIV)
  ) u_prescaler (
    .clk   (cLK),
    .rst_n (rst_n),
    .tick  (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // The new duty only lands at the wrap, so a period in flight is never cut short.
  always_comb begin
    cnt_next  = cnt;
    duty_next = duty_q;
    if (tick) begin
      if (cnt == LAST) begin
        cnt_next  = '0;
        duty_next = bus.ADC;
      end else begin
        cnt_next  = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge cLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else if (tick) begin
      cnt    <= cnt_next;
      duty_q <= duty_next;
      pwm_q  <= (cnt_next < duty_next);
      stb_q  <= (cnt_next == '0);
    end
  end

  assign bus.PWM        = pwm_q;
  assign bus.PERIOD_STB = stb_q;

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - sixteen-instance PWM bench against a tick-count reference model
module tb_pwm_generator;
  import pwm_pkg::*;

  localparam int N  = 16;
  localparam int DW = DW_DEFAULT;
  localparam int P  = PERIOD;
`ifdef PWM_PRESCALE_EN
  localparam int PRESC = 4;
`else
  localparam int PRESC = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] adc    [N];
  logic          pwm_o  [N];
  logic          stb_o  [N];

  int checks = 0;
  int errors = 0;
  int k;
  int pc;
  int duty_m [N];
  int hi     [N];

  always #25 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pwm_generator_if #(.DW(DW)) bus ();
    assign bus.ADC  = adc[g];
    assign pwm_o[g] = bus.PWM;
    assign stb_o[g] = bus.PERIOD_STB;
    pwm_generator #(
      .DW        (DW),
      .PRESC_DIV (PRESC)
    ) dut (
      .cLK   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // k counts ticks since reset; the period index is k/P and the position within it k%P.
  function automatic int exp_pwm(input int i);
    return ((k % P) < duty_m[i]) ? 1 : 0;
  endfunction

  function automatic int exp_stb();
    return (k > 0 && (k % P) == 0) ? 1 : 0;
  endfunction

  task automatic model_reset();
    k  = 0;
    pc = 0;
    for (int i = 0; i < N; i++) duty_m[i] = 0;
  endtask

  task automatic model_edge();
    bit t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    t  = (pc == PRESC - 1);
    pc = t ? 0 : pc + 1;
    if (t) begin
      if ((k % P) == P - 1)
        for (int i = 0; i < N; i++) duty_m[i] = int'(adc[i]);
      k++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("pwm%0d k%0d", i, k), int'(pwm_o[i]), exp_pwm(i));
      check($sformatf("stb%0d k%0d", i, k), int'(stb_o[i]), exp_stb());
    end
  endtask

  task automatic run_to_wrap();
    int n;
    n = 0;
    while (!(((k % P) == P - 1) && (pc == PRESC - 1))) begin
      if (n >= 2 * P * PRESC) begin
        check("wrap_timeout", 0, 1);
        return;
      end
      cycle();
      n++;
    end
  endtask

  task automatic count_period(input int chg_idx, input int chg_at, input int chg_val);
    for (int i = 0; i < N; i++) hi[i] = 0;
    for (int c = 0; c < P * PRESC; c++) begin
      cycle();
      for (int i = 0; i < N; i++) hi[i] += int'(pwm_o[i]);
      if (c == chg_at) adc[chg_idx] = DW'(chg_val);
    end
  endtask

  initial begin
    int idx;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) adc[i] = DW'(i);
    model_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("reset_pwm", int'(pwm_o[i]), 0);
      check("reset_stb", int'(stb_o[i]), 0);
    end
    rst_n = 1'b1;

    // duty proportional to code for every instance, first period all low
    run_to_wrap();
    count_period(0, -1, 0);
    for (int i = 0; i < N; i++) check($sformatf("duty_count%0d", i), hi[i], i * PRESC);

    // code change mid-period only affects the following period
    adc[0] = DW'(3);
    run_to_wrap();
    count_period(0, 5 * PRESC, 12);
    check("chg_cur_period", hi[0], 3 * PRESC);
    check("full_on_p1", hi[15], 15 * PRESC);
    run_to_wrap();
    count_period(0, -1, 0);
    check("chg_next_period", hi[0], 12 * PRESC);
    check("full_on_p2", hi[15], 15 * PRESC);
    check("steady8", hi[8], 8 * PRESC);
    run_to_wrap();
    count_period(0, -1, 0);
    check("full_on_p3", hi[15], 15 * PRESC);

    // asynchronous reset in the middle of a high pulse
    run_to_wrap();
    for (int c = 0; c < 4 * PRESC + 1; c++) cycle();
    check("pre_rst_pwm10", int'(pwm_o[10]), 1);
    #10 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      check("async_rst_pwm", int'(pwm_o[i]), 0);
      check("async_rst_stb", int'(stb_o[i]), 0);
    end
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
    run_to_wrap();
    count_period(0, -1, 0);
    check("post_rst_duty10", hi[10], 10 * PRESC);
    check("post_rst_duty15", hi[15], 15 * PRESC);

    // randomized code changes at arbitrary times
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, N - 1));
        adc[idx] = DW'($urandom_range(0, P));
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_generator.md
Name: pwm_generator

Overview:
- Single-channel PWM generator driven by a 4-bit ADC code; the duty cycle is proportional to the code.
- Sits between the ADC sampling logic and an output pin/driver.
- Sixteen instances, one per ADC code, can share one clock.
- The duty code is latched once per PWM period, so output pulses are never truncated or glitched by ADC changes.

Parameters:
- DW, 4, ADC code width in bits. PWM period is PERIOD = 2^DW - 1 ticks (15 by default).
- PRESC_DIV, 1, clock divider for the tick enable. Used only when PWM_PRESCALE_EN is defined; legal range 1..65535.

Ports:
- cLK  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- ADC  input  DW  duty code; 0 means always low, 2^DW-1 means always high.
- PWM  output  1  registered PWM output.
- PERIOD_STB  output  1  registered one-tick pulse, high during the tick where cnt==0 (start of each period).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - cnt=0, duty_q=0, PWM=0, PERIOD_STB=0, prescaler count=0.
  - Takes effect immediately, including mid-period.
  - Release is sampled on the next rising edge of cLK.
- Tick: an internal enable. It is 1 every cycle when the prescaler is compiled out.
- Counter cnt (DW bits):
  - On each tick, cnt increments 0..PERIOD-1.
  - After PERIOD-1 it wraps to 0; it never reaches 2^DW-1.
  - No change on non-tick cycles.
- Duty latch: on the tick where cnt==PERIOD-1, duty_q <= ADC, effective for the period that starts at the wrap.
  - ADC changes at any other time are ignored until the next wrap.
  - The first period after reset uses duty_q=0, so PWM stays low for the first 15 ticks.
- Output: on each tick, PWM <= (cnt_next < duty_next), where cnt_next and duty_next are the values being loaded that same edge.
  - Result: PWM is high for exactly duty_q consecutive ticks starting at cnt==0, then low for PERIOD-duty_q ticks.
  - ADC=0: PWM constantly 0.
  - ADC=2^DW-1: PWM constantly 1, with no low gap across period boundaries.
- PERIOD_STB: on each tick, PERIOD_STB <= (cnt_next==0). It is cleared on the next tick.
- Comparison is unsigned. There are no overflow conditions beyond the cnt wrap.

Optional Feature:
- Macro: PWM_PRESCALE_EN.
- Defined:
  - A 16-bit prescaler counts 0..PRESC_DIV-1 on cLK.
  - tick=1 only when the prescaler is at PRESC_DIV-1; the prescaler then wraps.
  - PWM period becomes 15*PRESC_DIV cycles.
  - PRESC_DIV=1 is equivalent to the feature being disabled.
- Not defined: no prescaler logic is present; tick is tied to 1; PRESC_DIV is ignored.

Decomposition:
- Package pwm_pkg holds:
  - the DW default;
  - localparam-style constants PERIOD = 2^DW-1;
  - a function computing PERIOD from a width.
- Sub-module pwm_prescaler (clock, rst_n, tick output, PRESC_DIV parameter) is instantiated only under PWM_PRESCALE_EN.
- Counter, duty latch and compare stay in pwm_generator.

Test Plan (clock period 50 ns, prescaler disabled unless stated):
- Sixteen instances with ADC=0..15, reset then released: count PWM high cycles per period after the first period. Required: high count equals the ADC value for every instance; ADC=0 gives 0/15; ADC=15 gives 15/15.
- ADC=8 steady: PWM high for 8 cycles from cnt==0, low for 7. PERIOD_STB pulses every 15 cycles, aligned to the PWM rising edge.
- ADC changed 3→12 mid-period (cnt=5): current period stays at 3 high cycles; the next period has 12 high cycles.
- rst_n pulsed low mid-pulse with ADC=10: PWM and PERIOD_STB drop to 0 asynchronously before the next clock edge. After release: one all-low period, then 10/15 duty.
- ADC=15 across 3 periods: PWM never deasserts after the first latch; no single-cycle glitch at the wrap.
- PWM_PRESCALE_EN with PRESC_DIV=4, ADC=5: PWM high for 20 cycles and low for 40 cycles per 60-cycle period.
